id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised, pipelined instruction-decode stage for the RISC-V core. Successor to the single-cycle decode block.
- Holds the register file and the immediate sign-extender. Adds WB write-through, EX/MEM operand forwarding, load-use stall detection, flush, and a registered ID/EX pipeline boundary.
- Sits between the IF/ID register and the EX stage.

Parameters:
- XLEN, 32, datapath width in bits.
- REG_AW, 5, register address width; register count is 2**REG_AW.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = stall on every RAW hazard against a valid EX/MEM writer.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_inst  in  32  instruction word.
- if_pc, if_pc4  in  XLEN  PC and PC+4 of the instruction.
- ctl_sext_op  in  3  immediate type (SEXT_* codes).
- ctl_rf_we, ctl_rf_wsel  in  1, 2  writeback enable and source (RF_WSEL_*). Both are carried to EX.
- ctl_use_rs1, ctl_use_rs2  in  1 each  instruction reads rs1/rs2.
- ctl_is_load  in  1  instruction is a load; carried to EX.
- ex_we, ex_is_load  in  1  EX-stage instruction writes the RF / is a load.
- ex_rd  in  REG_AW  EX destination.
- ex_result  in  XLEN  EX ALU result.
- mem_we  in  1  MEM-stage instruction writes the RF.
- mem_rd  in  REG_AW  MEM destination.
- mem_wdata  in  XLEN  MEM writeback value.
- wb_we  in  1  WB register-file write enable.
- wb_rd  in  REG_AW  WB destination.
- wb_wdata  in  XLEN  WB writeback value.
- flush  in  1  squash the instruction entering ID/EX (branch/jump taken).
- id_stall  out  1  combinational; hold PC and IF/ID this cycle.
- idex_valid, idex_rf_we, idex_is_load  out  1  registered.
- idex_rf_wsel  out  2  registered.
- idex_rs1_val, idex_rs2_val, idex_ext, idex_pc, idex_pc4  out  XLEN  registered.
- idex_rd  out  REG_AW  registered.

Behaviour:
- Field extraction: rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7]. For REG_AW<5 the low REG_AW bits are used.
- Register file
  - 2**REG_AW x XLEN. Register 0 reads 0 and ignores writes.
  - Written at the clk rising edge when wb_we && wb_rd!=0.
  - All entries clear to 0 on rst.
- Operand select per source: forced to 0 if the index is 0. Otherwise priority is:
  1. EX: ex_we && ex_rd==rs && !ex_is_load -> ex_result.
  2. MEM: mem_we && mem_rd==rs -> mem_wdata.
  3. WB: wb_we && wb_rd==rs -> wb_wdata (same-cycle write-through).
  4. RF array.
  - With FWD_EN=0, steps 1 and 2 are disabled.
- Hazard (hz), for each used source with a nonzero index:
  - FWD_EN=1: hz when ex_we && ex_is_load && ex_rd==rs.
  - FWD_EN=0: hz when (ex_we && ex_rd==rs) || (mem_we && mem_rd==rs).
  - id_stall = if_valid && hz && !flush.
- Immediate: SEXT_I inst[31:20]; SEXT_S {inst[31:25],inst[11:7]}; SEXT_B {inst[31],inst[7],inst[30:25],inst[11:8],0}; SEXT_U {inst[31:12],12'b0}; SEXT_J {inst[31],inst[19:12],inst[20],inst[30:21],0}. All are sign-extended to XLEN; unknown op gives 0.
- ID/EX register update, at each rising edge:
  - flush: bubble.
  - else id_stall: bubble (IF/ID holds, so the instruction re-decodes next cycle).
  - else: load decoded values; idex_valid = if_valid; idex_rf_we = ctl_rf_we && if_valid.
- Bubble: valid=0, rf_we=0, is_load=0. The data fields are don't-care but are driven to 0.
- Reset: all idex_* outputs are 0 and the RF is cleared, asynchronously. id_stall stays combinational; it is 0 while reset is asserted because if_valid is 0.
- Latency: one cycle from IF/ID to the idex_* outputs. A load-use stall costs exactly one bubble, after which the operand arrives via MEM forwarding.
- Simultaneous events: flush overrides stall. A WB write and an ID read of the same register in the same cycle returns the new value.

Decomposition:
- Shared defines header: SEXT_I/S/B/U/J and RF_WSEL_ALU/PC4/EXT/RDO codes, plus the instruction field bit positions.
- One sub-module, rf_bypass: parametrised register file with x0 hardwiring, async clear, and WB write-through read ports.
- Forwarding, hazard and the ID/EX register stay in the top level.

Test Plan:
- WB write-through: wb_we=1, wb_rd=5, wb_wdata=0x1234; same cycle decode rs1=5 -> next cycle idex_rs1_val=0x1234 (no stall).
- EX forward: ex_we=1, ex_rd=3, ex_is_load=0, ex_result=0xAA; decode rs2=3 -> idex_rs2_val=0xAA; MEM writer also targeting rd 3 with 0xBB loses.
- Load-use: ex_is_load=1, ex_rd=7; decode use_rs1 with rs1=7 -> id_stall=1 for one cycle, bubble (idex_valid=0). Next cycle mem_rd=7, mem_wdata=0x55 -> idex_rs1_val=0x55.
- Flush while a stall is pending -> id_stall=0, idex_valid=0, idex_rf_we=0.
- x0: wb_we=1, wb_rd=0, wb_wdata=0xFFFF; later read rs1=0 -> idex_rs1_val=0. Also an EX writer to rd 0 is never forwarded.
- Immediate/reset: SEXT_B with inst=0xFE000EE3 -> idex_ext=0xFFFFFFFC. Assert rst mid-run -> all idex_* outputs 0 immediately, and all RF reads return 0 afterwards.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions: immediate types, writeback-source codes and
// instruction field positions used by the pipelined decode stage.
package id_stage_pipe_pkg;

    typedef enum logic [2:0] {
        SEXT_I = 3'd0,
        SEXT_S = 3'd1,
        SEXT_B = 3'd2,
        SEXT_U = 3'd3,
        SEXT_J = 3'd4
    } sext_op_e;

    typedef enum logic [1:0] {
        RF_WSEL_ALU = 2'd0,
        RF_WSEL_PC4 = 2'd1,
        RF_WSEL_EXT = 2'd2,
        RF_WSEL_RDO = 2'd3
    } rf_wsel_e;

    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RD_LSB  = 7;

    // 32-bit sign-extended immediate; callers resize to the datapath width.
    function automatic logic [31:0] sext_imm(input logic [2:0] op, input logic [31:0] inst);
        logic [31:0] imm;
        case (op)
            SEXT_I:  imm = {{20{inst[31]}}, inst[31:20]};
            SEXT_S:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            SEXT_B:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            SEXT_U:  imm = {inst[31:12], 12'b0};
            SEXT_J:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_pipe_rf_bypass.sv
// Register file with x0 hardwired to zero, async clear, and two read ports
// that return the writeback value when it targets the register being read.
module id_stage_pipe_rf_bypass
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [REG_AW-1:0]           waddr,
    input  logic [XLEN-1:0]             wdata,
    input  logic [1:0][REG_AW-1:0]      raddr,
    output logic [1:0][XLEN-1:0]        rdata
);

    localparam int NREG = 2 ** REG_AW;

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem_q[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            assign rdata[gi] = (raddr[gi] == '0)                ? '0    :
                               (we && waddr == raddr[gi])       ? wdata :
                                                                  mem_q[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: operand fetch with EX/MEM/WB bypass, load-use
// stall detection, immediate generation and the registered ID/EX boundary.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [31:0]         if_inst,
    input  logic [XLEN-1:0]     if_pc,
    input  logic [XLEN-1:0]     if_pc4,
    input  logic [2:0]          ctl_sext_op,
    input  logic                ctl_rf_we,
    input  logic [1:0]          ctl_rf_wsel,
    input  logic                ctl_use_rs1,
    input  logic                ctl_use_rs2,
    input  logic                ctl_is_load,
    input  logic                ex_we,
    input  logic                ex_is_load,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic [XLEN-1:0]     ex_result,
    input  logic                mem_we,
    input  logic [REG_AW-1:0]   mem_rd,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_wdata,
    input  logic                flush,
    output logic                id_stall,
    output logic                idex_valid,
    output logic                idex_rf_we,
    output logic                idex_is_load,
    output logic [1:0]          idex_rf_wsel,
    output logic [XLEN-1:0]     idex_rs1_val,
    output logic [XLEN-1:0]     idex_rs2_val,
    output logic [XLEN-1:0]     idex_ext,
    output logic [XLEN-1:0]     idex_pc,
    output logic [XLEN-1:0]     idex_pc4,
    output logic [REG_AW-1:0]   idex_rd
);

    localparam logic FWD = (FWD_EN != 0);

    logic [1:0][REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0]      rd_idx;
    logic [1:0]             src_use;
    logic [1:0][XLEN-1:0]   rf_rdata;
    logic [1:0][XLEN-1:0]   opnd;
    logic [1:0]             src_hz;
    logic                   bubble;
    logic                   unused_inst;

    assign rs_idx[0]   = if_inst[RS1_LSB +: REG_AW];
    assign rs_idx[1]   = if_inst[RS2_LSB +: REG_AW];
    assign rd_idx      = if_inst[RD_LSB +: REG_AW];
    assign src_use     = {ctl_use_rs2, ctl_use_rs1};
    assign unused_inst = ^if_inst[6:0];

    id_stage_pipe_rf_bypass #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_we),
        .waddr (wb_rd),
        .wdata (wb_wdata),
        .raddr (rs_idx),
        .rdata (rf_rdata)
    );

    // Loads are never forwarded from EX: their data only exists from MEM on.
    always_comb begin
        opnd   = rf_rdata;
        src_hz = '0;
        for (int i = 0; i < 2; i++) begin
            if (rs_idx[i] == '0) begin
                opnd[i] = '0;
            end else if (FWD && ex_we && !ex_is_load && ex_rd == rs_idx[i]) begin
                opnd[i] = ex_result;
            end else if (FWD && mem_we && mem_rd == rs_idx[i]) begin
                opnd[i] = mem_wdata;
            end
            if (src_use[i] && rs_idx[i] != '0) begin
                if (FWD) begin
                    src_hz[i] = ex_we && ex_is_load && ex_rd == rs_idx[i];
                end else begin
                    src_hz[i] = (ex_we && ex_rd == rs_idx[i]) || (mem_we && mem_rd == rs_idx[i]);
                end
            end
        end
    end

    assign id_stall = if_valid && (|src_hz) && !flush;
    assign bubble   = flush || id_stall;

    logic                valid_d, rf_we_d, is_load_d;
    logic                valid_q, rf_we_q, is_load_q;
    logic [1:0]          wsel_d, wsel_q;
    logic [XLEN-1:0]     rs1_d, rs2_d, ext_d, pc_d, pc4_d;
    logic [XLEN-1:0]     rs1_q, rs2_q, ext_q, pc_q, pc4_q;
    logic [REG_AW-1:0]   rd_d, rd_q;

    always_comb begin
        valid_d   = 1'b0;
        rf_we_d   = 1'b0;
        is_load_d = 1'b0;
        wsel_d    = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        ext_d     = '0;
        pc_d      = '0;
        pc4_d     = '0;
        rd_d      = '0;
        if (!bubble) begin
            valid_d   = if_valid;
            rf_we_d   = ctl_rf_we && if_valid;
            is_load_d = ctl_is_load;
            wsel_d    = ctl_rf_wsel;
            rs1_d     = opnd[0];
            rs2_d     = opnd[1];
            ext_d     = XLEN'($signed(sext_imm(ctl_sext_op, if_inst)));
            pc_d      = if_pc;
            pc4_d     = if_pc4;
            rd_d      = rd_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            is_load_q <= 1'b0;
            wsel_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            ext_q     <= '0;
            pc_q      <= '0;
            pc4_q     <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            rf_we_q   <= rf_we_d;
            is_load_q <= is_load_d;
            wsel_q    <= wsel_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            ext_q     <= ext_d;
            pc_q      <= pc_d;
            pc4_q     <= pc4_d;
            rd_q      <= rd_d;
        end
    end

    assign idex_valid   = valid_q;
    assign idex_rf_we   = rf_we_q;
    assign idex_is_load = is_load_q;
    assign idex_rf_wsel = wsel_q;
    assign idex_rs1_val = rs1_q;
    assign idex_rs2_val = rs2_q;
    assign idex_ext     = ext_q;
    assign idex_pc      = pc_q;
    assign idex_pc4     = pc4_q;
    assign idex_rd      = rd_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed vector bench for the pipelined decode stage: forwarding priority,
// load-use stall, flush, x0, immediates and asynchronous reset.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [4:0]  R0 = 5'd0;
    localparam logic [2:0]  SX = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst, if_pc, if_pc4;
    logic [2:0]  ctl_sext_op;
    logic        ctl_rf_we;
    logic [1:0]  ctl_rf_wsel;
    logic        ctl_use_rs1, ctl_use_rs2, ctl_is_load;
    logic        ex_we, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_wdata;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        id_stall, idex_valid, idex_rf_we, idex_is_load;
    logic [1:0]  idex_rf_wsel;
    logic [31:0] idex_rs1_val, idex_rs2_val, idex_ext, idex_pc, idex_pc4;
    logic [4:0]  idex_rd;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .if_pc4       (if_pc4),
        .ctl_sext_op  (ctl_sext_op),
        .ctl_rf_we    (ctl_rf_we),
        .ctl_rf_wsel  (ctl_rf_wsel),
        .ctl_use_rs1  (ctl_use_rs1),
        .ctl_use_rs2  (ctl_use_rs2),
        .ctl_is_load  (ctl_is_load),
        .ex_we        (ex_we),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd),
        .mem_wdata    (mem_wdata),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_wdata     (wb_wdata),
        .flush        (flush),
        .id_stall     (id_stall),
        .idex_valid   (idex_valid),
        .idex_rf_we   (idex_rf_we),
        .idex_is_load (idex_is_load),
        .idex_rf_wsel (idex_rf_wsel),
        .idex_rs1_val (idex_rs1_val),
        .idex_rs2_val (idex_rs2_val),
        .idex_ext     (idex_ext),
        .idex_pc      (idex_pc),
        .idex_pc4     (idex_pc4),
        .idex_rd      (idex_rd)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sext;
        logic        rf_we;
        logic [1:0]  wsel;
        logic        ld, u1, u2, vld, fl;
        logic        ex_we, ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_wd;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_wd;
        logic        e_stall, e_valid, e_rfwe, e_ld;
        logic [1:0]  e_wsel;
        logic [31:0] e_rs1, e_rs2, e_ext;
        logic [4:0]  e_rd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vec [NVEC];

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] e_pc;
        @(negedge clk);
        if_inst = v.inst;        ctl_sext_op = v.sext;     ctl_rf_we = v.rf_we;
        ctl_rf_wsel = v.wsel;    ctl_is_load = v.ld;       ctl_use_rs1 = v.u1;
        ctl_use_rs2 = v.u2;      if_valid = v.vld;         flush = v.fl;
        ex_we = v.ex_we;         ex_is_load = v.ex_ld;     ex_rd = v.ex_rd;
        ex_result = v.ex_res;    mem_we = v.mem_we;        mem_rd = v.mem_rd;
        mem_wdata = v.mem_wd;    wb_we = v.wb_we;          wb_rd = v.wb_rd;
        wb_wdata = v.wb_wd;
        if_pc  = 32'h1000 + 32'(idx) * 32'd4;
        if_pc4 = if_pc + 32'd4;
        e_pc   = (v.e_stall || v.fl) ? 32'h0 : if_pc;
        #1;
        chk("id_stall", idx, 32'(id_stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        $display("vec %0d: stall=%0b valid=%0b rf_we=%0b rs1=%h rs2=%h ext=%h rd=%0d",
                 idx, v.e_stall, idex_valid, idex_rf_we, idex_rs1_val, idex_rs2_val, idex_ext, idex_rd);
        chk("idex_valid",   idx, 32'(idex_valid),   32'(v.e_valid));
        chk("idex_rf_we",   idx, 32'(idex_rf_we),   32'(v.e_rfwe));
        chk("idex_is_load", idx, 32'(idex_is_load), 32'(v.e_ld));
        chk("idex_rf_wsel", idx, 32'(idex_rf_wsel), 32'(v.e_wsel));
        chk("idex_rs1_val", idx, idex_rs1_val, v.e_rs1);
        chk("idex_rs2_val", idx, idex_rs2_val, v.e_rs2);
        chk("idex_ext",     idx, idex_ext,     v.e_ext);
        chk("idex_rd",      idx, 32'(idex_rd), 32'(v.e_rd));
        chk("idex_pc",      idx, idex_pc,      e_pc);
        chk("idex_pc4",     idx, idex_pc4,     (e_pc == 32'h0) ? 32'h0 : e_pc + 32'd4);
    endtask

    task automatic chk_all_zero(input int idx);
        chk("rst_valid",   idx, 32'(idex_valid),   Z);
        chk("rst_rf_we",   idx, 32'(idex_rf_we),   Z);
        chk("rst_is_load", idx, 32'(idex_is_load), Z);
        chk("rst_wsel",    idx, 32'(idex_rf_wsel), Z);
        chk("rst_rs1",     idx, idex_rs1_val,      Z);
        chk("rst_rs2",     idx, idex_rs2_val,      Z);
        chk("rst_ext",     idx, idex_ext,          Z);
        chk("rst_pc",      idx, idex_pc,           Z);
        chk("rst_pc4",     idx, idex_pc4,          Z);
        chk("rst_rd",      idx, 32'(idex_rd),      Z);
    endtask

    initial begin
        // inst, sext, rf_we, wsel, ld, u1, u2, vld, fl | ex we,ld,rd,res | mem we,rd,wd | wb we,rd,wd
        // | e_stall, e_valid, e_rfwe, e_ld, e_wsel, e_rs1, e_rs2, e_ext, e_rd
        vec[0]  = '{enc_r(R0, 5'd5, 5'd1), SX, T, 2'd2, T, T, F, T, F,  F, F, R0, Z,  F, R0, Z,  T, 5'd5, 32'h1234,
                    F, T, T, T, 2'd2, 32'h1234, Z, Z, 5'd1};
        vec[1]  = '{enc_r(R0, 5'd5, 5'd2), SX, T, 2'd0, F, T, F, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                    F, T, T, F, 2'd0, 32'h1234, Z, Z, 5'd2};
        vec[2]  = '{enc_r(5'd3, 5'd5, 5'd3), SX, T, 2'd1, F, T, T, T, F,  T, F, 5'd3, 32'hAA,  T, 5'd3, 32'hBB,  F, R0, Z,
                    F, T, T, F, 2'd1, 32'h1234, 32'hAA, Z, 5'd3};
        vec[3]  = '{enc_r(5'd3, 5'd5, 5'd4), SX, T, 2'd0, F, T, T, T, F,  T, F, 5'd4, 32'h11,  T, 5'd3, 32'hBB,  T, 5'd3, 32'hCC,
                    F, T, T, F, 2'd0, 32'h1234, 32'hBB, Z, 5'd4};
        vec[4]  = '{enc_r(5'd3, R0, 5'd5), SX, T, 2'd0, F, F, T, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                    F, T, T, F, 2'd0, Z, 32'hCC, Z, 5'd5};
        vec[5]  = '{enc_r(R0, R0, 5'd6), SX, T, 2'd0, F, T, T, T, F,  T, F, R0, 32'h77,  F, R0, Z,  T, R0, 32'hFFFF,
                    F, T, T, F, 2'd0, Z, Z, Z, 5'd6};
        vec[6]  = '{enc_r(R0, 5'd7, 5'd2), SX, T, 2'd0, F, T, F, T, F,  T, T, 5'd7, 32'h99,  F, R0, Z,  F, R0, Z,
                    T, F, F, F, 2'd0, Z, Z, Z, R0};
        vec[7]  = '{enc_r(R0, 5'd7, 5'd2), SX, T, 2'd0, F, T, F, T, F,  F, F, R0, Z,  T, 5'd7, 32'h55,  F, R0, Z,
                    F, T, T, F, 2'd0, 32'h55, Z, Z, 5'd2};
        vec[8]  = '{enc_r(5'd3, R0, 5'd9), SX, T, 2'd0, F, F, T, T, F,  T, T, 5'd3, 32'h42,  F, R0, Z,  F, R0, Z,
                    T, F, F, F, 2'd0, Z, Z, Z, R0};
        vec[9]  = '{enc_r(R0, 5'd7, 5'd2), SX, T, 2'd0, F, F, F, T, F,  T, T, 5'd7, 32'h99,  F, R0, Z,  F, R0, Z,
                    F, T, T, F, 2'd0, Z, Z, Z, 5'd2};
        vec[10] = '{enc_r(R0, 5'd7, 5'd2), SX, T, 2'd3, T, T, F, T, T,  T, T, 5'd7, 32'h99,  F, R0, Z,  F, R0, Z,
                    F, F, F, F, 2'd0, Z, Z, Z, R0};
        vec[11] = '{enc_r(R0, 5'd7, 5'd2), SX, T, 2'd0, F, T, F, F, F,  T, T, 5'd7, 32'h99,  F, R0, Z,  F, R0, Z,
                    F, F, F, F, 2'd0, Z, Z, Z, 5'd2};
        vec[12] = '{32'hFE000EE3, SEXT_B, F, 2'd0, F, F, F, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                    F, T, F, F, 2'd0, Z, Z, 32'hFFFFFFFC, 5'd29};
        vec[13] = '{32'h80000013, SEXT_I, T, 2'd0, F, F, F, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                    F, T, T, F, 2'd0, Z, Z, 32'hFFFFF800, R0};
        vec[14] = '{32'h800000A3, SEXT_S, F, 2'd0, F, F, F, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                    F, T, F, F, 2'd0, Z, Z, 32'hFFFFF801, 5'd1};
        vec[15] = '{32'h12345037, SEXT_U, T, 2'd2, F, F, F, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                    F, T, T, F, 2'd2, Z, 32'hCC, 32'h12345000, R0};
        vec[16] = '{32'h800000EF, SEXT_J, T, 2'd1, F, F, F, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                    F, T, T, F, 2'd1, Z, Z, 32'hFFF00000, 5'd1};

        rst = 1'b1;
        if_valid = 1'b0; if_inst = Z; if_pc = Z; if_pc4 = Z;
        ctl_sext_op = 3'd0; ctl_rf_we = 1'b0; ctl_rf_wsel = 2'd0;
        ctl_use_rs1 = 1'b0; ctl_use_rs2 = 1'b0; ctl_is_load = 1'b0;
        ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = R0; ex_result = Z;
        mem_we = 1'b0; mem_rd = R0; mem_wdata = Z;
        wb_we = 1'b0; wb_rd = R0; wb_wdata = Z; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero(-1);
        chk("rst_id_stall", -1, 32'(id_stall), Z);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(vec[i], i);
        end

        // Asynchronous reset mid-cycle, after a valid instruction was latched.
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero(NVEC);
        @(negedge clk);
        rst = 1'b0;

        // RF was cleared: r5 (0x1234) and r3 (0xCC) now read 0.
        apply('{enc_r(5'd3, 5'd5, 5'd1), SX, T, 2'd0, F, T, T, T, F,  F, F, R0, Z,  F, R0, Z,  F, R0, Z,
                F, T, T, F, 2'd0, Z, Z, Z, 5'd1}, NVEC + 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
